// File: rtl/shot_sequencer_pkg.sv
// Shared constants, index width, FSM state encoding and player ids for the shot sequencer.
package shot_sequencer_pkg;

  localparam int GRID_CELLS = 36;
  localparam int IDX_W      = 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TURN    = 3'd1,
    S_DECODE  = 3'd2,
    S_RESOLVE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/onehot_to_index36.sv
// Combinational 36-bit target to 6-bit cell index; the highest set bit wins, onehot_ok_o flags exactly one bit set.
module onehot_to_index36
  import shot_sequencer_pkg::*;
(
  input  logic [GRID_CELLS-1:0] onehot_i,
  output logic [IDX_W-1:0]      index_o,
  output logic                  onehot_ok_o
);

  always_comb begin
    index_o = '0;
    for (int i = 0; i < GRID_CELLS; i++) begin
      if (onehot_i[i]) index_o = IDX_W'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign onehot_ok_o = (onehot_i != '0) &&
                       ((onehot_i & (onehot_i - GRID_CELLS'(1))) == '0);

endmodule

// File: rtl/shot_sequencer.sv
// Two-player battleship turn sequencer: result 2 cycles after shot acceptance, one shot in flight, shot_ready low outside TURN.
// Define ONEHOT_CHECK_EN to reject multi-hot targets; otherwise the highest set bit selects the cell.
module shot_sequencer
  import shot_sequencer_pkg::*;
#(
  parameter int GRID_CELLS  = shot_sequencer_pkg::GRID_CELLS,
  parameter int HITS_TO_WIN = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [GRID_CELLS-1:0] p0_ships,
  input  logic [GRID_CELLS-1:0] p1_ships,
  input  logic                  shot_valid,
  input  logic [GRID_CELLS-1:0] shot_target,
  output logic                  shot_ready,
  output logic                  active_player,
  output logic                  result_valid,
  output logic                  result_hit,
  output logic [IDX_W-1:0]      result_index,
  output logic                  shot_error,
  output logic [GRID_CELLS-1:0] fired0,
  output logic [GRID_CELLS-1:0] fired1,
  output logic                  game_over,
  output logic                  winner
);

  localparam logic [IDX_W-1:0] WIN_CNT = IDX_W'(HITS_TO_WIN);

  state_e                state_q;
  logic [GRID_CELLS-1:0] target_q, ships0_q, ships1_q, fired0_q, fired1_q;
  logic [IDX_W-1:0]      idx_q, hits0_q, hits1_q, result_index_q;
  logic                  shot_ready_q, active_q, result_valid_q, result_hit_q;
  logic                  shot_error_q, game_over_q, winner_q;

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_onehot;
  logic                  reject_multi;
  logic                  dec_bad_d, hit_d;
  logic [IDX_W-1:0]      cnt_d;
  logic [GRID_CELLS-1:0] fired_act, ships_opp;

  onehot_to_index36 u_dec (
    .onehot_i    (target_q),
    .index_o     (dec_idx),
    .onehot_ok_o (dec_onehot)
  );

`ifdef ONEHOT_CHECK_EN
  assign reject_multi = 1'b1;
`else
  assign reject_multi = 1'b0;
`endif

  always_comb begin
    fired_act = (active_q == P0) ? fired0_q : fired1_q;
    ships_opp = (active_q == P0) ? ships1_q : ships0_q;
    dec_bad_d = (target_q == '0) || (reject_multi && !dec_onehot) || fired_act[dec_idx];
    hit_d     = ships_opp[idx_q];
    cnt_d     = ((active_q == P0) ? hits0_q : hits1_q) + IDX_W'(hit_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      target_q       <= '0;
      ships0_q       <= '0;
      ships1_q       <= '0;
      fired0_q       <= '0;
      fired1_q       <= '0;
      idx_q          <= '0;
      hits0_q        <= '0;
      hits1_q        <= '0;
      result_index_q <= '0;
      shot_ready_q   <= 1'b0;
      active_q       <= P0;
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      shot_error_q   <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= P0;
    end else begin
      result_valid_q <= 1'b0;
      shot_error_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            ships0_q     <= p0_ships;
            ships1_q     <= p1_ships;
            fired0_q     <= '0;
            fired1_q     <= '0;
            hits0_q      <= '0;
            hits1_q      <= '0;
            game_over_q  <= 1'b0;
            winner_q     <= P0;
            active_q     <= P0;
            shot_ready_q <= 1'b1;
            state_q      <= S_TURN;
          end
        end
        S_TURN: begin
          if (shot_valid && shot_ready_q) begin
            target_q     <= shot_target;
            shot_ready_q <= 1'b0;
            state_q      <= S_DECODE;
          end
        end
        S_DECODE: begin
          idx_q <= dec_idx;
          if (dec_bad_d) begin
            shot_error_q <= 1'b1;
            shot_ready_q <= 1'b1;
            state_q      <= S_TURN;
          end else begin
            state_q <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          result_valid_q <= 1'b1;
          result_hit_q   <= hit_d;
          result_index_q <= idx_q;
          if (active_q == P0) begin
            fired0_q[idx_q] <= 1'b1;
            hits0_q         <= cnt_d;
          end else begin
            fired1_q[idx_q] <= 1'b1;
            hits1_q         <= cnt_d;
          end
          // The win test uses the post-increment count so the final hit ends the game immediately.
          if (cnt_d == WIN_CNT) begin
            game_over_q <= 1'b1;
            winner_q    <= active_q;
            state_q     <= S_DONE;
          end else begin
            active_q     <= (active_q == P0) ? P1 : P0;
            shot_ready_q <= 1'b1;
            state_q      <= S_TURN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign shot_ready    = shot_ready_q;
  assign active_player = active_q;
  assign result_valid  = result_valid_q;
  assign result_hit    = result_hit_q;
  assign result_index  = result_index_q;
  assign shot_error    = shot_error_q;
  assign fired0        = fired0_q;
  assign fired1        = fired1_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Scoreboarded bench for shot_sequencer: directed game plus randomized shots against a rule-level game model.
module tb_shot_sequencer;

  localparam int N   = 36;
  localparam int WIN = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  p0_ships = '0;
  logic [N-1:0]  p1_ships = '0;
  logic          shot_valid = 1'b0;
  logic [N-1:0]  shot_target = '0;
  logic          shot_ready, active_player, result_valid, result_hit, shot_error;
  logic          game_over, winner;
  logic [5:0]    result_index;
  logic [N-1:0]  fired0, fired1;

  shot_sequencer #(.GRID_CELLS(N), .HITS_TO_WIN(WIN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .p0_ships      (p0_ships),
    .p1_ships      (p1_ships),
    .shot_valid    (shot_valid),
    .shot_target   (shot_target),
    .shot_ready    (shot_ready),
    .active_player (active_player),
    .result_valid  (result_valid),
    .result_hit    (result_hit),
    .result_index  (result_index),
    .shot_error    (shot_error),
    .fired0        (fired0),
    .fired1        (fired1),
    .game_over     (game_over),
    .winner        (winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           err;
    bit           hit;
    int           idx;
    bit           act;
    bit           over;
    bit           win;
    logic [N-1:0] f0;
    logic [N-1:0] f1;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Game model: ship maps, shots taken, hit tallies, whose turn, winner.
  logic [N-1:0] m_ships [2];
  logic [N-1:0] m_fired [2];
  int           m_hits  [2];
  int           m_turn;
  bit           m_over;
  int           m_winner;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [N-1:0] rnd_cells();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[N-1:0];
  endfunction

  task automatic model_shot(input logic [N-1:0] t, output exp_t e);
    int top = -1;
    int ones = 0;
    for (int i = 0; i < N; i++) if (t[i]) begin top = i; ones++; end
    e.err = (ones == 0);
`ifdef ONEHOT_CHECK_EN
    if (ones > 1) e.err = 1'b1;
`endif
    if (!e.err && m_fired[m_turn][top]) e.err = 1'b1;
    e.hit = 1'b0;
    e.idx = 0;
    if (!e.err) begin
      e.idx = top;
      e.hit = m_ships[1 - m_turn][top];
      m_fired[m_turn][top] = 1'b1;
      if (e.hit) m_hits[m_turn]++;
      if (m_hits[m_turn] == WIN) begin
        m_over   = 1'b1;
        m_winner = m_turn;
      end else begin
        m_turn = 1 - m_turn;
      end
    end
    e.act  = m_turn[0];
    e.over = m_over;
    e.win  = m_winner[0];
    e.f0   = m_fired[0];
    e.f1   = m_fired[1];
    e.cyc  = 0;
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid || shot_error) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_pulse", $sformatf("result_valid=%0b shot_error=%0b with no shot outstanding",
                 result_valid, shot_error));
      end else begin
        e = sb.pop_front();
        chk("shot_error", shot_error, e.err);
        chk("result_valid", result_valid, !e.err);
        chk("latency_cycle", cyc, e.cyc);
        if (!e.err) begin
          chk("result_hit", result_hit, e.hit);
          chk("result_index", result_index, e.idx);
        end
        chk("active_player", active_player, e.act);
        chk("game_over", game_over, e.over);
        chk("shot_ready", shot_ready, !e.over);
        chk("fired0", fired0, e.f0);
        chk("fired1", fired1, e.f1);
        if (e.over) chk("winner", winner, e.win);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_shot_ready"}, shot_ready, 0);
    chk({tag, "_active"}, active_player, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_result_hit"}, result_hit, 0);
    chk({tag, "_result_index"}, result_index, 0);
    chk({tag, "_shot_error"}, shot_error, 0);
    chk({tag, "_fired0"}, fired0, 0);
    chk({tag, "_fired1"}, fired1, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_winner"}, winner, 0);
  endtask

  task automatic do_start(input logic [N-1:0] s0, input logic [N-1:0] s1);
    p0_ships = s0;
    p1_ships = s1;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    p0_ships = rnd_cells();
    p1_ships = rnd_cells();
    m_ships[0] = s0;  m_ships[1] = s1;
    m_fired[0] = '0;  m_fired[1] = '0;
    m_hits[0]  = 0;   m_hits[1]  = 0;
    m_turn = 0;  m_over = 1'b0;  m_winner = 0;
    @(negedge clk);
    chk("start_shot_ready", shot_ready, 1);
    chk("start_active", active_player, 0);
    chk("start_fired0", fired0, 0);
    chk("start_fired1", fired1, 0);
    chk("start_game_over", game_over, 0);
  endtask

  task automatic shoot(input logic [N-1:0] t);
    exp_t e;
    int   n = 0;
    bit   extra;
    while (!shot_ready && n < 20) begin @(negedge clk); n++; end
    if (!shot_ready) begin
      fail_now("shot_ready_timeout", "shot_ready=0 expected 1 within 20 cycles");
      return;
    end
    model_shot(t, e);
    e.cyc = cyc + (e.err ? 2 : 3);
    sb.push_back(e);
    shot_valid  = 1'b1;
    shot_target = t;
    @(posedge clk); #1;
    // Optionally keep shot_valid up and pulse start through DECODE; both must be ignored.
    extra = ($urandom_range(0, 1) == 1);
    if (extra) begin
      start       = 1'b1;
      shot_target = rnd_cells();
      @(posedge clk); #1;
      start = 1'b0;
    end
    shot_valid  = 1'b0;
    shot_target = rnd_cells();
    n = 0;
    while (sb.size() != 0 && n < 10) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      fail_now("result_timeout", "no result_valid/shot_error within 10 cycles");
      sb.delete();
    end
  endtask

  function automatic logic [N-1:0] pick_target(input int mode);
    logic [N-1:0] t;
    int a, b, off;
    t = '0;
    a = $urandom_range(0, N - 1);
    if (mode < 7) begin
      t[a] = 1'b1;
    end else if (mode == 8) begin
      b = (a + 1 + $urandom_range(0, N - 2)) % N;
      t[a] = 1'b1;
      t[b] = 1'b1;
    end else if (mode == 9) begin
      off = a;
      for (int k = 0; k < N; k++) begin
        if (m_fired[m_turn][(off + k) % N]) begin
          t[(off + k) % N] = 1'b1;
          break;
        end
      end
    end
    return t;
  endfunction

  initial begin
    logic [N-1:0] t;
    logic [N-1:0] dir_list [7];
    int guard;

    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    // Directed game: P0 hits cell 5, P1 misses cell 0, repeat, multi-hot, zero target, then P0 finishes.
    do_start(36'd1 << 10, (36'd1 << 5) | (36'd1 << 7));
    dir_list[0] = 36'd1 << 5;
    dir_list[1] = 36'd1 << 0;
    dir_list[2] = 36'd1 << 5;
    dir_list[3] = 36'h3;
    dir_list[4] = 36'h0;
    dir_list[5] = 36'd1 << 1;
    dir_list[6] = 36'd1 << 7;
    foreach (dir_list[i]) if (!m_over) shoot(dir_list[i]);
    guard = 0;
    while (!m_over && guard < 40) begin
      t = '0;
      for (int k = 0; k < N; k++) begin
        if (m_turn == 0 && m_ships[1][k] && !m_fired[0][k]) begin t[k] = 1'b1; break; end
        if (m_turn == 1 && !m_ships[0][k] && !m_fired[1][k]) begin t[k] = 1'b1; break; end
      end
      shoot(t);
      guard++;
    end
    chk("dir_game_over", game_over, 1);
    chk("dir_winner", winner, 0);
    chk("dir_done_ready", shot_ready, 0);

    // Shots presented in DONE must not be taken.
    shot_valid  = 1'b1;
    shot_target = 36'd1 << 20;
    repeat (3) @(negedge clk);
    shot_valid = 1'b0;
    chk("done_ignore_fired0", fired0, m_fired[0]);
    chk("done_ignore_ready", shot_ready, 0);

    do_start(rnd_cells(), rnd_cells());

    for (int s = 0; s < 400; s++) begin
      if (m_over) do_start(rnd_cells(), rnd_cells());
      shoot(pick_target($urandom_range(0, 9)));
    end

    // Reset asserted while a shot sits in DECODE.
    if (m_over) do_start(rnd_cells(), rnd_cells());
    t = '0;
    for (int k = 0; k < N; k++) if (!m_fired[m_turn][k]) begin t[k] = 1'b1; break; end
    shot_valid  = 1'b1;
    shot_target = t;
    @(posedge clk); #1;
    shot_valid = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    check_zero("rst_decode");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shot_sequencer.md
SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 SHALL have parameter GRID_CELLS, default 36, number of board cells (6x6 grid).
REQ-002 SHALL have parameter HITS_TO_WIN, default 9, ship cells per player that must be hit to win.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a new game and latch ship maps.
REQ-006 SHALL have port p0_ships  input  36  player-0 ship map, bit i set = ship in cell i.
REQ-007 SHALL have port p1_ships  input  36  player-1 ship map.
REQ-008 SHALL have port shot_valid  input  1  a target is presented.
REQ-009 SHALL have port shot_target  input  36  one-hot target cell from keyboard decode.
REQ-010 SHALL have port shot_ready  output  1  sequencer can accept a shot.
REQ-011 SHALL have port active_player  output  1  player whose turn it is.
REQ-012 SHALL have port result_valid  output  1  one-cycle pulse, shot resolved.
REQ-013 SHALL have port result_hit  output  1  resolved shot struck a ship, valid with result_valid.
REQ-014 SHALL have port result_index  output  6  binary cell index of resolved shot.
REQ-015 SHALL have port shot_error  output  1  one-cycle pulse, shot rejected.
REQ-016 SHALL have port fired0 / fired1  output  36 each  cells fired by player 0 / player 1.
REQ-017 SHALL have port game_over  output  1  a winner exists; winner  output  1  winning player.

Function
REQ-018 SHALL implement FSM IDLE -> TURN -> DECODE -> RESOLVE -> TURN | DONE; DONE -> TURN on start.
REQ-019 IDLE/DONE: shot_ready=0; start (1 cycle) latches both ship maps, clears fired0/1, both hit counters and game_over, sets active_player=0, and enters TURN.
REQ-020 TURN: shot_ready=1; shot accepted on shot_valid&&shot_ready, and shot_target is registered; the next state is DECODE.
REQ-021 DECODE (1 cycle): the registered target SHALL be converted to a 6-bit index and checked for validity.
REQ-022 A target that is zero, or whose cell is already set in the active player's fired mask, SHALL pulse shot_error, return to TURN, and keep active_player unchanged with no other state change.
REQ-023 RESOLVE (1 cycle): the sequencer SHALL set the fired bit and compute hit = opponent ship bit; it SHALL pulse result_valid with result_hit/result_index and increment the active player's 6-bit hit counter on hit.
REQ-024 After RESOLVE, if the counter equals HITS_TO_WIN, the FSM SHALL enter DONE with game_over=1 and winner=active_player; otherwise it SHALL toggle active_player and enter TURN.
REQ-025 Latency from shot acceptance to result_valid SHALL be exactly 2 cycles; at most one shot SHALL be in flight.
REQ-026 start outside IDLE/DONE SHALL be ignored; shot_valid outside TURN SHALL be ignored (not queued).
REQ-027 Index conversion of a multi-hot target without the check in REQ-030 SHALL use the highest set bit.

Reset
REQ-028 While rst_n=0, the sequencer SHALL be in IDLE; all outputs, fired masks, hit counters and latched ship maps SHALL be 0.
REQ-029 Reset asserted mid-turn (any state) SHALL abort the in-flight shot with no result_valid or shot_error pulse.

Configuration
REQ-030 With ONEHOT_CHECK_EN defined, a multi-hot target SHALL be rejected via shot_error as in REQ-022; without it, REQ-027 SHALL apply and a multi-hot target SHALL not be an error.

Structure
REQ-031 The shared package SHALL hold GRID_CELLS, the 6-bit index width, the FSM state encoding, and the player-id constants P0=0, P1=1.
REQ-032 Index conversion SHALL be a sub-module onehot_to_index36 (36-bit in, 6-bit index and onehot_ok out).

Verification
REQ-033 Reset, then start, with p1_ships=1<<5 and P0 target=1<<5 -> 2 cycles later result_valid=1, result_hit=1, result_index=5, active_player=1.
REQ-034 P1 target 1<<0 with p0_ships bit 0 clear -> result_hit=0, fired1[0]=1, active_player=0.
REQ-035 P0 repeats target 1<<5 -> shot_error pulse, no result_valid, active_player stays 0.
REQ-036 With HITS_TO_WIN=2, P0 makes two hits -> game_over=1, winner=0, shot_ready=0; a following start restores TURN with cleared masks.
REQ-037 Target 36'h3 -> shot_error if ONEHOT_CHECK_EN is defined, else result_index=1; target 0 -> shot_error in both builds.
REQ-038 rst_n pulsed low during DECODE -> no result_valid or shot_error, and all outputs 0 in IDLE.
